// File: rtl/oven_pkg.sv
// Shared definitions for the oven program controller: phase codes, the
// sel-to-step tables and the saturating step helper.
package oven_pkg;

  typedef enum logic [2:0] {
    T_ENTRY = 3'd0,
    D_ENTRY = 3'd1,
    PREHEAT = 3'd2,
    COOK    = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5
  } oven_state_t;

  localparam int SAT_W = 16;

  function automatic logic [SAT_W-1:0] temp_step(input logic [4:0] sel);
    case (sel)
      5'b00001: return 16'd5;
      5'b00010: return 16'd10;
      5'b00100: return 16'd25;
      5'b01000: return 16'd50;
      5'b10000: return 16'd100;
      default:  return 16'd0;
    endcase
  endfunction

  function automatic logic [SAT_W-1:0] time_step(input logic [4:0] sel);
    case (sel)
      5'b00001: return 16'd5;
      5'b00010: return 16'd10;
      5'b00100: return 16'd30;
      5'b01000: return 16'd60;
      5'b10000: return 16'd300;
      default:  return 16'd0;
    endcase
  endfunction

  // The extra top bit catches both overflow and borrow before clamping.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] val,
                                                input logic [SAT_W-1:0] step,
                                                input logic             up,
                                                input logic [SAT_W-1:0] lo,
                                                input logic [SAT_W-1:0] hi);
    logic [SAT_W:0] w_sum;
    if (up) begin
      w_sum = {1'b0, val} + {1'b0, step};
      if (w_sum > {1'b0, hi}) return hi;
    end else begin
      w_sum = {1'b0, val} - {1'b0, step};
      if (w_sum[SAT_W] || (w_sum < {1'b0, lo})) return lo;
    end
    return w_sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/oven_key_gesture.sv
// Turns the two active-low pushbuttons into one-cycle inc/dec/confirm pulses
// using two registered samples of each key level.
module oven_key_gesture
(
  input  logic clk,
  input  logic pwr,
  input  logic i_keyInc,
  input  logic i_keyDec,
  output logic o_inc,
  output logic o_dec,
  output logic o_confirm
);

  logic r_incLvl, r_decLvl, r_incPrev, r_decPrev;
  logic w_both, w_bothPrev;

  always_ff @(posedge clk) begin
    if (!pwr) begin
      r_incLvl  <= 1'b1;
      r_decLvl  <= 1'b1;
      r_incPrev <= 1'b1;
      r_decPrev <= 1'b1;
    end else begin
      r_incLvl  <= i_keyInc;
      r_decLvl  <= i_keyDec;
      r_incPrev <= r_incLvl;
      r_decPrev <= r_decLvl;
    end
  end

  // Confirm wins; a single-key fall only counts while the other key is up.
  assign w_both     = ~r_incLvl & ~r_decLvl;
  assign w_bothPrev = ~r_incPrev & ~r_decPrev;
  assign o_confirm  = w_both & ~w_bothPrev;
  assign o_inc      = ~o_confirm & r_incPrev & ~r_incLvl & r_decLvl;
  assign o_dec      = ~o_confirm & r_decPrev & ~r_decLvl & r_incLvl;

endmodule

// File: rtl/oven_program_ctrl.sv
// Multi-stage oven program controller: stage entry, preheat, countdown, done.
// Optional pause during COOK is built in when OVEN_PAUSE_EN is defined.
module oven_program_ctrl
  import oven_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int TEMP_W       = 10,
  parameter int TIME_W       = 13,
  parameter int TEMP_MIN     = 65,
  parameter int TEMP_MAX     = 500,
  parameter int TEMP_DEFAULT = 300,
  parameter int TIME_MAX     = 1800,
  parameter int TICK_DIV     = 50000000
)
(
  input  logic              clk,
  input  logic              pwr,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic [4:0]        sel,
  input  logic [TEMP_W-1:0] cur_temp,
  output logic              heat,
  output logic [2:0]        state,
  output logic [2:0]        stage_idx,
  output logic [TEMP_W-1:0] target_temp,
  output logic [TIME_W-1:0] remaining,
  output logic              done
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  oven_state_t       r_state;
  logic [2:0]        r_stageIdx;
  logic [3:0]        r_len;
  logic [TEMP_W-1:0] r_temp [NUM_STAGES];
  logic [TIME_W-1:0] r_time [NUM_STAGES];
  logic [TIME_W-1:0] r_remain;
  logic [PS_W-1:0]   r_ps;
  logic              r_heat, r_done;

  logic              w_inc, w_dec, w_confirm, w_paused;
  logic [IDX_W-1:0]  w_idx;
  logic [TEMP_W-1:0] w_setTemp, w_tempNext;
  logic [TIME_W-1:0] w_setTime, w_timeNext;
  logic              w_lastProg, w_lastSlot, w_tick;

  oven_key_gesture u_gesture (
    .clk       (clk),
    .pwr       (pwr),
    .i_keyInc  (key_inc),
    .i_keyDec  (key_dec),
    .o_inc     (w_inc),
    .o_dec     (w_dec),
    .o_confirm (w_confirm)
  );

  assign w_idx      = r_stageIdx[IDX_W-1:0];
  assign w_setTemp  = r_temp[w_idx];
  assign w_setTime  = r_time[w_idx];
  assign w_tempNext = TEMP_W'(sat_step(SAT_W'(w_setTemp), temp_step(sel), w_inc,
                                       SAT_W'(TEMP_MIN), SAT_W'(TEMP_MAX)));
  assign w_timeNext = TIME_W'(sat_step(SAT_W'(w_setTime), time_step(sel), w_inc,
                                       SAT_W'(0), SAT_W'(TIME_MAX)));
  assign w_lastProg = ({1'b0, r_stageIdx} == (r_len - 4'd1));
  assign w_lastSlot = (r_stageIdx == 3'(NUM_STAGES - 1));
  assign w_tick     = (r_ps == PS_LAST);

`ifdef OVEN_PAUSE_EN
  logic r_paused;
  assign w_paused = r_paused;
`else
  assign w_paused = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!pwr) begin
      r_state    <= T_ENTRY;
      r_stageIdx <= '0;
      r_len      <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_temp[i] <= TEMP_W'(TEMP_DEFAULT);
        r_time[i] <= '0;
      end
      r_remain   <= '0;
      r_ps       <= '0;
      r_heat     <= 1'b0;
      r_done     <= 1'b0;
`ifdef OVEN_PAUSE_EN
      r_paused   <= 1'b0;
`endif
    end else begin
      r_heat <= ((r_state == PREHEAT) || (r_state == COOK)) && !w_paused &&
                (cur_temp < w_setTemp);
      case (r_state)
        T_ENTRY: begin
          if (w_confirm) r_state <= D_ENTRY;
          else if (w_inc || w_dec) r_temp[w_idx] <= w_tempNext;
        end
        // A zero duration terminates the program unless nothing is programmed yet.
        D_ENTRY: begin
          if (w_confirm) begin
            if (w_setTime == '0) begin
              if (r_stageIdx != 3'd0) begin
                r_len      <= {1'b0, r_stageIdx};
                r_stageIdx <= '0;
                r_state    <= PREHEAT;
              end
            end else if (w_lastSlot) begin
              r_len      <= 4'(NUM_STAGES);
              r_stageIdx <= '0;
              r_state    <= PREHEAT;
            end else begin
              r_stageIdx <= r_stageIdx + 3'd1;
              r_state    <= T_ENTRY;
            end
          end else if (w_inc || w_dec) begin
            r_time[w_idx] <= w_timeNext;
          end
        end
        PREHEAT: begin
          if ((cur_temp >= w_setTemp) || ((r_stageIdx != 3'd0) && (cur_temp > w_setTemp))) begin
            r_state  <= COOK;
            r_remain <= w_setTime;
            r_ps     <= '0;
          end
        end
        COOK: begin
`ifdef OVEN_PAUSE_EN
          if (w_confirm) r_paused <= ~r_paused;
`endif
          if (!w_paused) begin
            if (w_tick) begin
              r_ps     <= '0;
              r_remain <= r_remain - TIME_W'(1);
              if (r_remain == TIME_W'(1)) begin
`ifdef OVEN_PAUSE_EN
                r_paused <= 1'b0;
`endif
                if (w_lastProg) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_stageIdx <= r_stageIdx + 3'd1;
                  r_state    <= PREHEAT;
                end
              end
            end else begin
              r_ps <= r_ps + PS_W'(1);
            end
          end
        end
        DONE:    r_done  <= 1'b1;
        default: r_state <= T_ENTRY;
      endcase
    end
  end

  assign state       = w_paused ? PAUSE : r_state;
  assign stage_idx   = r_stageIdx;
  assign target_temp = w_setTemp;
  assign remaining   = ((r_state == T_ENTRY) || (r_state == D_ENTRY)) ? w_setTime : r_remain;
  assign heat        = r_heat;
  assign done        = r_done;

endmodule
